// File: rtl/dac_spi_scheduler_if.sv
// Request/acknowledge bus from the configuration logic plus the shared DAC serial pins.
// The master side presents command words; the slave side is the scheduler.
interface dac_spi_scheduler_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  sup_req;
    logic [DATA_WIDTH-1:0] sup_data;
    logic                  sup_ack;
    logic                  rng_req;
    logic [DATA_WIDTH-1:0] rng_data;
    logic                  rng_ack;
    logic                  busy;
    logic                  sclk;
    logic                  sdio;
    logic                  supdac_csb;
    logic                  rngdac_csb;

    modport master (
        output sup_req, sup_data, rng_req, rng_data,
        input  sup_ack, rng_ack, busy, sclk, sdio, supdac_csb, rngdac_csb
    );

    modport slave (
        input  sup_req, sup_data, rng_req, rng_data,
        output sup_ack, rng_ack, busy, sclk, sdio, supdac_csb, rngdac_csb
    );
endinterface

// File: rtl/dac_spi_scheduler.sv
// Round-robin scheduler sharing one SPI mode-0 write bus between the supply and range DACs.
// Every output is a register; the next-state process computes all register inputs.
module dac_spi_scheduler #(
    parameter int DATA_WIDTH = 24,
    parameter int CLK_DIV    = 4
) (
    input  logic               sys_clk,
    input  logic               reset,
    dac_spi_scheduler_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    localparam int              BW       = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [7:0]      DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [BW-1:0]   BIT_LAST = BW'(DATA_WIDTH - 1);

    state_t                state_q, state_d;
    logic [7:0]            div_q, div_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  sel_sup_q, sel_sup_d;
    logic                  last_sup_q, last_sup_d;
    logic                  sclk_q, sclk_d;
    logic                  sdio_q, sdio_d;
    logic                  sup_csb_q, sup_csb_d;
    logic                  rng_csb_q, rng_csb_d;
    logic                  sup_ack_q, sup_ack_d;
    logic                  rng_ack_q, rng_ack_d;
    logic                  busy_q, busy_d;

    logic                  div_end;
    logic                  pick_sup;
    logic [DATA_WIDTH-1:0] grant_word;

    assign div_end    = (div_q == DIV_LAST);
    // A tie goes to whichever requester was not served last.
    assign pick_sup   = bus.sup_req && (!bus.rng_req || !last_sup_q);
    assign grant_word = pick_sup ? bus.sup_data : bus.rng_data;

    // NOTE: every variable gets its default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        sel_sup_d  = sel_sup_q;
        last_sup_d = last_sup_q;
        sclk_d     = sclk_q;
        sdio_d     = sdio_q;
        sup_csb_d  = sup_csb_q;
        rng_csb_d  = rng_csb_q;
        sup_ack_d  = 1'b0;
        rng_ack_d  = 1'b0;
        busy_d     = busy_q;

        case (state_q)
            IDLE: begin
                if (bus.sup_req || bus.rng_req) begin
                    sel_sup_d  = pick_sup;
                    last_sup_d = pick_sup;
                    shreg_d    = grant_word;
                    sdio_d     = grant_word[DATA_WIDTH-1];
                    sup_csb_d  = !pick_sup;
                    rng_csb_d  = pick_sup;
                    busy_d     = 1'b1;
                    div_d      = 8'd0;
                    bit_d      = '0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (div_end) begin
                    div_d   = 8'd0;
                    sclk_d  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            SHIFT: begin
                if (!div_end) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d = 8'd0;
                    if (sclk_q) begin
                        // Falling edge: present the next bit, holding the last one until csb rises.
                        sclk_d = 1'b0;
                        if (bit_q != BIT_LAST) begin
                            shreg_d = shreg_q << 1;
                            sdio_d  = shreg_q[DATA_WIDTH-2];
                        end
                    end else if (bit_q == BIT_LAST) begin
                        sup_csb_d = 1'b1;
                        rng_csb_d = 1'b1;
                        sdio_d    = 1'b0;
                        sup_ack_d = sel_sup_q;
                        rng_ack_d = !sel_sup_q;
                        state_d   = GAP;
                    end else begin
                        bit_d  = bit_q + BW'(1);
                        sclk_d = 1'b1;
                    end
                end
            end
            GAP: begin
                if (div_end) begin
                    div_d   = 8'd0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same old values.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            div_q      <= 8'd0;
            bit_q      <= '0;
            shreg_q    <= '0;
            sel_sup_q  <= 1'b0;
            last_sup_q <= 1'b0;
            sclk_q     <= 1'b0;
            sdio_q     <= 1'b0;
            sup_csb_q  <= 1'b1;
            rng_csb_q  <= 1'b1;
            sup_ack_q  <= 1'b0;
            rng_ack_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            sel_sup_q  <= sel_sup_d;
            last_sup_q <= last_sup_d;
            sclk_q     <= sclk_d;
            sdio_q     <= sdio_d;
            sup_csb_q  <= sup_csb_d;
            rng_csb_q  <= rng_csb_d;
            sup_ack_q  <= sup_ack_d;
            rng_ack_q  <= rng_ack_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.sclk       = sclk_q;
    assign bus.sdio       = sdio_q;
    assign bus.supdac_csb = sup_csb_q;
    assign bus.rngdac_csb = rng_csb_q;
    assign bus.sup_ack    = sup_ack_q;
    assign bus.rng_ack    = rng_ack_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_dac_spi_scheduler.sv
// Bench for dac_spi_scheduler: a default instance (CLK_DIV=4) and a CLK_DIV=1 instance.
// A pin monitor turns each chip-select window into an observed transfer for the scoreboard.
module tb_dac_spi_scheduler;

    typedef struct {
        int          inst;
        bit          sup;
        logic [23:0] data;
    } exp_t;

    typedef struct {
        int          inst;
        bit          sup;
        logic [23:0] data;
        int          nbits;
        int          len;
        int          toggles;
        int          glitch;
        int          gap;
        bit          ack_ok;
    } obs_t;

    logic sys_clk = 1'b0;
    logic reset   = 1'b1;

    always #10 sys_clk = ~sys_clk;

    dac_spi_scheduler_if #(.DATA_WIDTH(24)) bus_a ();
    dac_spi_scheduler_if #(.DATA_WIDTH(24)) bus_b ();

    dac_spi_scheduler #(.DATA_WIDTH(24), .CLK_DIV(4)) dut_a (
        .sys_clk(sys_clk), .reset(reset), .bus(bus_a)
    );
    dac_spi_scheduler #(.DATA_WIDTH(24), .CLK_DIV(1)) dut_b (
        .sys_clk(sys_clk), .reset(reset), .bus(bus_b)
    );

    exp_t exp_q[$];
    obs_t obs_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    bit          in_xfer[2];
    bit          cur_sup[2];
    bit          have_prev[2];
    logic [23:0] cap[2];
    logic        prev_sclk[2];
    logic        prev_sdio[2];
    int          nbits[2], len[2], tog[2], glitch[2], gap[2], gap_start[2];
    int          sup_acks[2], rng_acks[2];
    int          both_low      = 0;
    int          sclk_idle_bad = 0;

    task automatic mon_step(input int k, input logic s_csb, input logic r_csb, input logic sck,
                            input logic sd, input logic s_ack, input logic r_ack);
        obs_t o;
        if (reset) begin
            in_xfer[k] = 0; have_prev[k] = 0; gap[k] = 0;
            prev_sclk[k] = 1'b0; prev_sdio[k] = 1'b0;
            return;
        end
        if (s_ack === 1'b1) sup_acks[k]++;
        if (r_ack === 1'b1) rng_acks[k]++;
        if (s_csb === 1'b0 && r_csb === 1'b0) both_low++;
        if (s_csb === 1'b0 || r_csb === 1'b0) begin
            if (!in_xfer[k]) begin
                in_xfer[k] = 1; cur_sup[k] = (s_csb === 1'b0); cap[k] = '0;
                nbits[k] = 0; len[k] = 0; tog[k] = 0; glitch[k] = 0;
                gap_start[k] = have_prev[k] ? gap[k] : -1;
            end
            len[k]++;
            if (sck !== prev_sclk[k]) tog[k]++;
            if (sck === 1'b1 && prev_sclk[k] === 1'b0) begin
                cap[k] = {cap[k][22:0], sd};
                nbits[k]++;
            end
            if (sck === 1'b1 && sd !== prev_sdio[k]) glitch[k]++;
        end else begin
            if (sck !== 1'b0) sclk_idle_bad++;
            if (in_xfer[k]) begin
                o.inst = k; o.sup = cur_sup[k]; o.data = cap[k]; o.nbits = nbits[k];
                o.len = len[k]; o.toggles = tog[k]; o.glitch = glitch[k]; o.gap = gap_start[k];
                o.ack_ok = cur_sup[k] ? (s_ack === 1'b1 && r_ack === 1'b0)
                                      : (r_ack === 1'b1 && s_ack === 1'b0);
                obs_q.push_back(o);
                in_xfer[k] = 0; have_prev[k] = 1; gap[k] = 1;
            end else begin
                gap[k]++;
            end
        end
        prev_sclk[k] = sck;
        prev_sdio[k] = sd;
    endtask

    always @(negedge sys_clk) begin
        mon_step(0, bus_a.supdac_csb, bus_a.rngdac_csb, bus_a.sclk, bus_a.sdio, bus_a.sup_ack, bus_a.rng_ack);
        mon_step(1, bus_b.supdac_csb, bus_b.rngdac_csb, bus_b.sclk, bus_b.sdio, bus_b.sup_ack, bus_b.rng_ack);
    end

    task automatic push_exp(input int inst, input bit sup, input logic [23:0] data);
        exp_t e;
        e.inst = inst; e.sup = sup; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic wait_obs(input int n, input int budget, input string name);
        for (int i = 0; i < budget && obs_q.size() < n; i++) @(negedge sys_clk);
        n_cmp++;
        if (obs_q.size() < n) begin
            n_err++;
            $display("FAIL %s_timeout: got %0d transfers, want %0d", name, obs_q.size(), n);
        end
    endtask

    task automatic test_reset;
        bus_a.sup_req = 0; bus_a.rng_req = 0; bus_a.sup_data = '0; bus_a.rng_data = '0;
        bus_b.sup_req = 0; bus_b.rng_req = 0; bus_b.sup_data = '0; bus_b.rng_data = '0;
        reset = 1'b1;
        repeat (3) @(negedge sys_clk);
        n_cmp++;
        if ({bus_a.supdac_csb, bus_a.rngdac_csb, bus_a.sclk, bus_a.sdio, bus_a.sup_ack, bus_a.rng_ack, bus_a.busy} !== 7'b1100000) begin
            n_err++;
            $display("FAIL reset_a: got %b, want 1100000", {bus_a.supdac_csb, bus_a.rngdac_csb, bus_a.sclk, bus_a.sdio, bus_a.sup_ack, bus_a.rng_ack, bus_a.busy});
        end
        n_cmp++;
        if ({bus_b.supdac_csb, bus_b.rngdac_csb, bus_b.sclk, bus_b.sdio, bus_b.sup_ack, bus_b.rng_ack, bus_b.busy} !== 7'b1100000) begin
            n_err++;
            $display("FAIL reset_b: got %b, want 1100000", {bus_b.supdac_csb, bus_b.rngdac_csb, bus_b.sclk, bus_b.sdio, bus_b.sup_ack, bus_b.rng_ack, bus_b.busy});
        end
        reset = 1'b0;
        repeat (3) @(negedge sys_clk);
        n_cmp++;
        if (bus_a.busy !== 1'b0 || bus_a.supdac_csb !== 1'b1) begin
            n_err++;
            $display("FAIL idle_after_reset: busy=%b csb=%b, want busy=0 csb=1", bus_a.busy, bus_a.supdac_csb);
        end
    endtask

    task automatic test_alternate;
        int sa0, ra0, bl0, cnt, i;
        exp_t e;
        obs_t o;
        sa0 = sup_acks[0]; ra0 = rng_acks[0]; bl0 = both_low;
        bus_a.sup_data = 24'h111111; bus_a.rng_data = 24'h222222;
        bus_a.sup_req = 1; bus_a.rng_req = 1;
        push_exp(0, 1, 24'h111111);
        push_exp(0, 0, 24'h222222);
        push_exp(0, 1, 24'h111111);
        for (i = 0; i < 2000; i++) begin
            @(negedge sys_clk);
            if (obs_q.size() >= 2 && bus_a.supdac_csb === 1'b0) break;
        end
        n_cmp++;
        if (i >= 2000) begin
            n_err++;
            $display("FAIL alt_third_grant: saw %0d transfers, want third sup grant", obs_q.size());
        end
        bus_a.sup_req = 0; bus_a.rng_req = 0;
        wait_obs(3, 1000, "alt");
        repeat (300) @(negedge sys_clk);
        cnt = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++;
            if (o.sup !== e.sup || o.data !== e.data || o.nbits != 24 || o.len != 196 || !o.ack_ok) begin
                n_err++;
                $display("FAIL alt_xfer%0d: got sup=%b data=%h bits=%0d len=%0d ack=%b, want sup=%b data=%h bits=24 len=196 ack=1",
                         cnt, o.sup, o.data, o.nbits, o.len, o.ack_ok, e.sup, e.data);
            end
            if (cnt > 0) begin
                n_cmp++;
                if (o.gap < 4) begin
                    n_err++;
                    $display("FAIL alt_gap%0d: got %0d csb-high cycles, want >= 4", cnt, o.gap);
                end
            end
            cnt++;
        end
        n_cmp++;
        if (cnt != 3 || obs_q.size() != 0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL alt_count: got %0d matched, %0d extra, want 3 and 0", cnt, obs_q.size());
            obs_q.delete(); exp_q.delete();
        end
        n_cmp++;
        if (sup_acks[0] - sa0 != 2 || rng_acks[0] - ra0 != 1 || both_low != bl0) begin
            n_err++;
            $display("FAIL alt_acks: got sup=%0d rng=%0d overlap=%0d, want 2 1 0",
                     sup_acks[0] - sa0, rng_acks[0] - ra0, both_low - bl0);
        end
    endtask

    task automatic test_single;
        int sa0, ra0, cnt;
        exp_t e;
        obs_t o;
        sa0 = sup_acks[0]; ra0 = rng_acks[0];
        bus_a.sup_data = 24'hA5F00F; bus_a.sup_req = 1;
        push_exp(0, 1, 24'hA5F00F);
        @(negedge sys_clk);
        bus_a.sup_req = 0;
        n_cmp++;
        if (bus_a.supdac_csb !== 1'b0 || bus_a.rngdac_csb !== 1'b1 || bus_a.busy !== 1'b1 || bus_a.sdio !== 1'b1) begin
            n_err++;
            $display("FAIL single_latency: got csb=%b/%b busy=%b sdio=%b, want 0/1 1 1",
                     bus_a.supdac_csb, bus_a.rngdac_csb, bus_a.busy, bus_a.sdio);
        end
        wait_obs(1, 400, "single");
        repeat (10) @(negedge sys_clk);
        cnt = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++;
            if (o.sup !== e.sup || o.data !== e.data || o.nbits != 24 || o.len != 196 ||
                o.toggles != 48 || o.glitch != 0 || !o.ack_ok) begin
                n_err++;
                $display("FAIL single_xfer: got sup=%b data=%h bits=%0d len=%0d tog=%0d glitch=%0d ack=%b, want sup=1 data=%h bits=24 len=196 tog=48 glitch=0 ack=1",
                         o.sup, o.data, o.nbits, o.len, o.toggles, o.glitch, o.ack_ok, e.data);
            end
            cnt++;
        end
        n_cmp++;
        if (cnt != 1 || bus_a.busy !== 1'b0 || sup_acks[0] - sa0 != 1 || rng_acks[0] != ra0) begin
            n_err++;
            $display("FAIL single_done: got xfers=%0d busy=%b sup_acks=%0d rng_acks=%0d, want 1 0 1 0",
                     cnt, bus_a.busy, sup_acks[0] - sa0, rng_acks[0] - ra0);
        end
    endtask

    task automatic test_data_change;
        int ra0, cnt, i;
        exp_t e;
        obs_t o;
        ra0 = rng_acks[0];
        bus_a.rng_data = 24'hC33C5A; bus_a.rng_req = 1;
        push_exp(0, 0, 24'hC33C5A);
        for (i = 0; i < 10 && bus_a.rngdac_csb !== 1'b0; i++) @(negedge sys_clk);
        repeat (40) @(negedge sys_clk);
        bus_a.rng_data = 24'h000001;
        for (i = 0; i < 400 && bus_a.rng_ack !== 1'b1; i++) @(negedge sys_clk);
        n_cmp++;
        if (bus_a.rng_ack !== 1'b1) begin
            n_err++;
            $display("FAIL chg_ack_timeout: got rng_ack=%b, want 1", bus_a.rng_ack);
        end
        bus_a.rng_req = 0;
        repeat (300) @(negedge sys_clk);
        cnt = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++;
            if (o.sup !== e.sup || o.data !== e.data || o.len != 196 || !o.ack_ok) begin
                n_err++;
                $display("FAIL chg_xfer: got sup=%b data=%h len=%0d ack=%b, want sup=0 data=%h len=196 ack=1",
                         o.sup, o.data, o.len, o.ack_ok, e.data);
            end
            cnt++;
        end
        n_cmp++;
        if (cnt != 1 || obs_q.size() != 0 || rng_acks[0] - ra0 != 1) begin
            n_err++;
            $display("FAIL chg_count: got xfers=%0d extra=%0d rng_acks=%0d, want 1 0 1", cnt, obs_q.size(), rng_acks[0] - ra0);
            obs_q.delete(); exp_q.delete();
        end
    endtask

    task automatic test_reset_mid;
        int sa0, cnt, i;
        exp_t e;
        obs_t o;
        sa0 = sup_acks[0];
        bus_a.sup_data = 24'h5A5A5A; bus_a.sup_req = 1;
        for (i = 0; i < 400 && !(in_xfer[0] && nbits[0] == 10); i++) @(negedge sys_clk);
        n_cmp++;
        if (!(in_xfer[0] && nbits[0] == 10)) begin
            n_err++;
            $display("FAIL mid_reach_bit10: got %0d bits, want 10", nbits[0]);
        end
        #3 reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus_a.supdac_csb, bus_a.sclk, bus_a.sdio, bus_a.busy} !== 4'b1000) begin
            n_err++;
            $display("FAIL mid_reset_pins: got csb,sclk,sdio,busy=%b, want 1000",
                     {bus_a.supdac_csb, bus_a.sclk, bus_a.sdio, bus_a.busy});
        end
        bus_a.rng_data = 24'h0F0F0F; bus_a.rng_req = 1;
        repeat (3) @(negedge sys_clk);
        n_cmp++;
        if (sup_acks[0] != sa0 || obs_q.size() != 0) begin
            n_err++;
            $display("FAIL mid_no_ack: got sup_acks=%0d xfers=%0d, want 0 0", sup_acks[0] - sa0, obs_q.size());
            obs_q.delete();
        end
        push_exp(0, 1, 24'h5A5A5A);
        reset = 1'b0;
        @(negedge sys_clk);
        n_cmp++;
        if (bus_a.supdac_csb !== 1'b0 || bus_a.rngdac_csb !== 1'b1) begin
            n_err++;
            $display("FAIL mid_tie_winner: got sup_csb=%b rng_csb=%b, want 0 1", bus_a.supdac_csb, bus_a.rngdac_csb);
        end
        bus_a.sup_req = 0; bus_a.rng_req = 0;
        wait_obs(1, 400, "mid");
        cnt = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++;
            if (o.sup !== e.sup || o.data !== e.data || o.len != 196 || !o.ack_ok) begin
                n_err++;
                $display("FAIL mid_xfer: got sup=%b data=%h len=%0d ack=%b, want sup=1 data=%h len=196 ack=1",
                         o.sup, o.data, o.len, o.ack_ok, e.data);
            end
            cnt++;
        end
        repeat (10) @(negedge sys_clk);
        n_cmp++;
        if (cnt != 1 || sup_acks[0] - sa0 != 1 || obs_q.size() != 0) begin
            n_err++;
            $display("FAIL mid_count: got xfers=%0d sup_acks=%0d, want 1 1", cnt, sup_acks[0] - sa0);
            obs_q.delete(); exp_q.delete();
        end
    endtask

    task automatic test_clkdiv1;
        int ra0, cnt;
        exp_t e;
        obs_t o;
        ra0 = rng_acks[1];
        bus_b.rng_data = 24'hFFFFFF; bus_b.rng_req = 1;
        push_exp(1, 0, 24'hFFFFFF);
        @(negedge sys_clk);
        bus_b.rng_req = 0;
        wait_obs(1, 200, "div1");
        repeat (5) @(negedge sys_clk);
        cnt = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++;
            if (o.inst != e.inst || o.sup !== e.sup || o.data !== e.data || o.nbits != 24 ||
                o.len != 49 || o.toggles != 48 || o.glitch != 0 || !o.ack_ok) begin
                n_err++;
                $display("FAIL div1_xfer: got inst=%0d sup=%b data=%h bits=%0d len=%0d tog=%0d ack=%b, want 1 0 %h 24 49 48 1",
                         o.inst, o.sup, o.data, o.nbits, o.len, o.toggles, o.ack_ok, e.data);
            end
            cnt++;
        end
        n_cmp++;
        if (cnt != 1 || rng_acks[1] - ra0 != 1 || bus_b.busy !== 1'b0) begin
            n_err++;
            $display("FAIL div1_done: got xfers=%0d rng_acks=%0d busy=%b, want 1 1 0", cnt, rng_acks[1] - ra0, bus_b.busy);
        end
    endtask

    task automatic test_bus_invariants;
        n_cmp++;
        if (both_low != 0 || sclk_idle_bad != 0) begin
            n_err++;
            $display("FAIL bus_invariants: got overlap=%0d idle_sclk_high=%0d, want 0 0", both_low, sclk_idle_bad);
        end
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_single();
        test_data_change();
        test_reset_mid();
        test_clkdiv1();
        test_bus_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dac_spi_scheduler.md
Name: dac_spi_scheduler

Overview:
Shares the single DAC serial bus (sclk, sdio) between the supply DAC and the range DAC, each with its own chip select. Two requesters present 24-bit command words. The block arbitrates round-robin, serialises the granted word MSB-first in SPI mode 0, and pulses an acknowledge to the requester on completion. It sits between the register-bridge/configuration logic and the DAC pins, in the sys_clk domain.

Parameters:
DATA_WIDTH, 24, bits per DAC command word.
CLK_DIV, 4, sys_clk cycles per sclk half-period; legal range 1..255.

Ports:
sys_clk  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-high reset
sup_req  input  1  supply-DAC write request (level)
sup_data  input  DATA_WIDTH  supply-DAC command word
sup_ack  output  1  one-cycle pulse when the supply-DAC transfer completes
rng_req  input  1  range-DAC write request (level)
rng_data  input  DATA_WIDTH  range-DAC command word
rng_ack  output  1  one-cycle pulse when the range-DAC transfer completes
busy  output  1  high from grant until GAP ends
sclk  output  1  serial clock, idles low
sdio  output  1  serial data out (write-only bus)
supdac_csb  output  1  supply-DAC chip select, active low
rngdac_csb  output  1  range-DAC chip select, active low

Behaviour:
- Reset (async assert, release on a sys_clk edge) sets the outputs as follows: sclk=0, sdio=0, supdac_csb=1, rngdac_csb=1, sup_ack=0, rng_ack=0, busy=0. State goes to IDLE. The last-grant pointer is set to rng, so sup wins the first tie.
- All outputs are registered. Neither chip select is ever low while the other is low.
- States: IDLE, SETUP, SHIFT, GAP.
- IDLE:
  - Requests are sampled here only.
  - If exactly one req is high, that requester is granted.
  - If both are high, the one not granted last is granted.
  - On grant, the granted data word is latched and the pointer is updated. On the next cycle: that requester's csb=0, sdio=MSB, busy=1, state goes to SETUP.
- SETUP: sclk low for CLK_DIV cycles, then SHIFT.
- SHIFT: for each bit, sclk is high for CLK_DIV cycles, then low for CLK_DIV cycles. sdio changes only on the high-to-low sclk transition, to the next bit. After the low phase of the final bit, state goes to GAP.
  - Result: exactly DATA_WIDTH rising sclk edges; data is stable at least CLK_DIV cycles either side of each rising edge.
- Transfer timing: csb is low for exactly CLK_DIV*(1+2*DATA_WIDTH) cycles; with defaults that is 196 cycles.
- GAP entry, same cycle: csb returns to 1, sdio=0, and the granted ack pulses high for exactly 1 cycle.
- GAP lasts CLK_DIV cycles with both csb high. busy drops on the GAP-to-IDLE transition.
  - A req still high in IDLE starts a new transfer; back-to-back requests from one requester are therefore legal.
  - A requester must drop req in the cycle after its ack if it wants no repeat.
- Req or data changes after grant are ignored. A req dropped mid-transfer does not abort it, and ack still pulses.
- Both reqs held continuously give strict alternation: sup, rng, sup, …
- Reset mid-transfer: immediate csb high, sclk low, sdio 0, no ack, pointer reset.
- Latency from req seen high in IDLE to csb low: 1 cycle. From req to ack, uncontended: 1 + CLK_DIV*(1+2*DATA_WIDTH) cycles.

Test Plan:
- sup_req=1, sup_data=24'hA5F00F, CLK_DIV=4 -> supdac_csb low 196 cycles; 24 sclk rising edges; bits captured on the rising edges equal A5F00F MSB-first; rngdac_csb stays 1; sup_ack pulses 1 cycle as csb rises.
- sup_req and rng_req asserted in the same cycle after reset, held -> grants alternate sup, rng, sup; each ack arrives once per transfer; the csb-high gap between transfers is at least 4 cycles; the two chip selects are never low together.
- rng_req pulse held until ack, rng_data changed to 24'h000001 mid-transfer -> the original word is shifted out; rng_ack pulses once; no second transfer follows.
- reset asserted at bit 10 of a sup transfer -> on the same edge, supdac_csb=1, sclk=0, sdio=0; no sup_ack; after release, sup wins a tie.
- CLK_DIV=1, DATA_WIDTH=24, rng_data=24'hFFFFFF -> csb low 49 cycles; sclk toggles every cycle; all captured bits are 1.
